// File: rtl/jt51_phram.sv
// jt51_phram: run-time loadable 32x46 phase table. A byte-serial loader fills the table; reads keep the fixed-table timing.
// Optional build macro JT51_PHRAM_CKSUM_EN adds a trailing checksum byte and the ld_err flag.
module jt51_phram #(
    parameter int AW = 5,
    parameter int DW = 46
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] ph,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          tbl_valid,
    output logic          ld_err
);
    localparam int NB = (DW + 7) / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] BLAST = BW'(NB - 1);

`ifdef JT51_PHRAM_CKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CKSUM} state_t;
`else
    typedef enum logic {IDLE, LOAD} state_t;
`endif

    state_t        state, state_nx;
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] asm_q, asm_nx;
    logic [BW-1:0] bcnt;
    logic [AW-1:0] ptr;
    logic          wr_pend;
    logic          acc, last_byte, last_entry;

    assign acc       = ld_valid && ld_ready && !ld_start;
    assign last_byte = bcnt == BLAST;
    // A pending write has not advanced ptr yet, so look one entry ahead
    assign last_entry = (wr_pend ? ptr + AW'(1) : ptr) == '1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ld_start) begin
            state_nx = LOAD;
        end else begin
            case (state)
                LOAD: if (acc && last_byte && last_entry)
`ifdef JT51_PHRAM_CKSUM_EN
                          state_nx = CKSUM;
                CKSUM: if (acc) state_nx = IDLE;
`else
                          state_nx = IDLE;
`endif
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        if (state != IDLE) begin
            ld_ready = 1'b1;
            ld_busy  = 1'b1;
        end
    end

    // Little-endian byte lane insert; bits of the top byte beyond DW-1 never exist
    always_comb begin
        asm_nx = asm_q;
        for (int unsigned b = 0; b < DW; b++)
            if (b / 8 == 32'(bcnt)) asm_nx[b] = ld_data[3'(b % 8)];
    end

`ifdef JT51_PHRAM_CKSUM_EN
    logic [7:0] sum, ck_total;
    assign ck_total = sum + ld_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt      <= '0;
            ptr       <= '0;
            wr_pend   <= 1'b0;
            tbl_valid <= 1'b0;
`ifdef JT51_PHRAM_CKSUM_EN
            sum       <= '0;
            ld_err    <= 1'b0;
`endif
        end else if (ld_start) begin
            bcnt      <= '0;
            ptr       <= '0;
            wr_pend   <= 1'b0;
            tbl_valid <= 1'b0;
`ifdef JT51_PHRAM_CKSUM_EN
            sum       <= '0;
            ld_err    <= 1'b0;
`endif
        end else begin
            if (wr_pend) begin
                ptr     <= ptr + 1'b1;
                wr_pend <= 1'b0;
`ifndef JT51_PHRAM_CKSUM_EN
                if (ptr == '1) tbl_valid <= 1'b1;
`endif
            end
            if (acc && state == LOAD) begin
                asm_q <= asm_nx;
`ifdef JT51_PHRAM_CKSUM_EN
                sum   <= ck_total;
`endif
                if (last_byte) begin
                    bcnt    <= '0;
                    wr_pend <= 1'b1;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
`ifdef JT51_PHRAM_CKSUM_EN
            if (acc && state == CKSUM) begin
                if (ck_total == 8'h00) tbl_valid <= 1'b1;
                else                   ld_err    <= 1'b1;
            end
`endif
        end
    end

`ifndef JT51_PHRAM_CKSUM_EN
    assign ld_err = 1'b0;
`endif

    // Entry is written the cycle after its last byte; a same-address read sees the old word
    always_ff @(posedge clk) begin
        if (wr_pend && !ld_start && !rst) ram[ptr] <= asm_q;
    end

    always_ff @(posedge clk) begin
        if (rst)      ph <= '0;
        else if (cen) ph <= ram[addr];
    end

endmodule

// File: tb/tb_jt51_phram.sv
// Randomized self-checking bench for jt51_phram; expected table built from the byte stream.
// Honours JT51_PHRAM_CKSUM_EN when defined for the build.
module tb_jt51_phram;
    localparam int AW = 5;
    localparam int DW = 46;
    localparam int NB = 6;
    localparam int NE = 32;
    localparam int NBYTES = NE * NB;

    logic          clk = 1'b0;
    logic          rst, cen, ld_start, ld_valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] ph;
    logic [7:0]    ld_data;
    logic          ld_ready, ld_busy, tbl_valid, ld_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_tab [NE];
    logic [DW-1:0] prev_tab [NE];
    logic [7:0]    stream [$];

    always #5 clk = ~clk;

    jt51_phram #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .addr(addr), .ph(ph),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .tbl_valid(tbl_valid), .ld_err(ld_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry e = little-endian concatenation of stream bytes e*NB .. e*NB+NB-1, truncated to DW
    function automatic void build_model();
        logic [NB*8-1:0] w;
        for (int e = 0; e < NE; e++) begin
            w = '0;
            for (int j = 0; j < NB; j++) w[8*j +: 8] = stream[e*NB + j];
            exp_tab[e] = w[DW-1:0];
        end
    endfunction

    task automatic read(input int a);
        addr = AW'(a);
        cen  = 1'b1;
        tick();
        cen  = 1'b0;
    endtask

    task automatic verify_table(input string tag);
        for (int e = 0; e < NE; e++) begin
            read(e);
            check($sformatf("%s[%0d]", tag, e), ph, exp_tab[e]);
        end
    endtask

    task automatic load(input int gapmod, input int stop_after, input bit collide,
                        input bit bad_ck, input logic [DW-1:0] old5);
        logic [7:0] s [$];
        logic [7:0] sum;
        int idx, budget, target;
        bit acc, wr5;
        s = stream;
        sum = '0;
        foreach (stream[i]) sum += stream[i];
`ifdef JT51_PHRAM_CKSUM_EN
        s.push_back(8'(-sum) + (bad_ck ? 8'd1 : 8'd0));
`endif
        target = (stop_after < s.size()) ? stop_after : s.size();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        idx = 0; budget = 0; wr5 = 1'b0;
        while (idx < target && budget < 5000) begin
            ld_valid = (gapmod <= 1) || ($urandom % gapmod == 0);
            ld_data  = s[idx];
            if (wr5) begin addr = AW'(5); cen = 1'b1; end
            else cen = 1'b0;
            acc = ld_valid && ld_ready;
            tick();
            budget++;
            if (wr5) begin
                check("collide_old", ph, old5);
                wr5 = 1'b0;
            end
            if (acc) begin
                idx++;
                if (collide && idx == 6*NB) wr5 = 1'b1;
            end
        end
        ld_valid = 1'b0;
        cen = 1'b0;
        check("load_bytes_accepted", idx, target);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cen = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; addr = '0;
        tick(); tick();
        check("rst_ph", ph, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ld_busy", ld_busy, 0);
        check("rst_tbl_valid", tbl_valid, 0);
        check("rst_ld_err", ld_err, 0);
        rst = 1'b0;
        tick();

        // Pattern A, no gaps
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(8'(i));
        build_model();
        load(1, NBYTES + 1, 1'b0, 1'b0, '0);
`ifndef JT51_PHRAM_CKSUM_EN
        check("tv_before_last_write", tbl_valid, 0);
`endif
        tick();
        check("a_tbl_valid", tbl_valid, 1);
        check("a_ld_busy", ld_busy, 0);
        check("a_ld_err", ld_err, 0);
        read(0);
        check("a_addr0", ph, 64'h05_0403_0201_00);
        read(31);
        check("a_addr31", ph, 64'h3F_BEBD_BCBB_BA);
        verify_table("a_tab");

        // Read enable low holds ph
        read(3);
        cen = 1'b0;
        for (int a = 0; a < NE; a++) begin
            addr = AW'(a);
            tick();
            check("cen0_hold", ph, exp_tab[3]);
        end
        addr = AW'(7); cen = 1'b1;
        tick();
        cen = 1'b0;
        check("cen1_addr7", ph, exp_tab[7]);

        // Restart mid-load with pattern B
        load(1, 100, 1'b0, 1'b0, '0);
        tick();
        check("partial_tbl_valid", tbl_valid, 0);
        check("partial_busy", ld_busy, 1);
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(~8'(i));
        build_model();
        load(1, NBYTES + 1, 1'b0, 1'b0, '0);
        tick();
        check("b_tbl_valid", tbl_valid, 1);
        verify_table("b_tab");

        // Pattern A with random gaps and a read colliding with the entry-5 write
        prev_tab = exp_tab;
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(8'(i));
        build_model();
        load(3, NBYTES + 1, 1'b1, 1'b0, prev_tab[5]);
        tick();
        check("gap_tbl_valid", tbl_valid, 1);
        verify_table("gap_tab");

        // Reset after 50 random bytes: entries 0..7 replaced, rest kept
        prev_tab = exp_tab;
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(8'($urandom));
        build_model();
        for (int e = 8; e < NE; e++) exp_tab[e] = prev_tab[e];
        load(2, 50, 1'b0, 1'b0, '0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", ld_busy, 0);
        check("rstmid_ready", ld_ready, 0);
        check("rstmid_tbl_valid", tbl_valid, 0);
        check("rstmid_ph", ph, 0);
        verify_table("rstmid_tab");

        // Random data, random gaps, random reads
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(8'($urandom));
        build_model();
        load(int'($urandom_range(1, 4)), NBYTES + 1, 1'b0, 1'b0, '0);
        tick();
        check("rnd_tbl_valid", tbl_valid, 1);
        for (int k = 0; k < 20; k++) begin
            int a;
            a = int'($urandom_range(0, NE - 1));
            read(a);
            check("rnd_read", ph, exp_tab[a]);
        end

`ifdef JT51_PHRAM_CKSUM_EN
        stream.delete();
        for (int i = 0; i < NBYTES; i++) stream.push_back(8'($urandom));
        build_model();
        load(2, NBYTES + 1, 1'b0, 1'b0, '0);
        tick();
        check("ck_pass_tv", tbl_valid, 1);
        check("ck_pass_err", ld_err, 0);
        load(2, NBYTES + 1, 1'b0, 1'b1, '0);
        tick();
        check("ck_fail_tv", tbl_valid, 0);
        check("ck_fail_err", ld_err, 1);
        repeat (5) tick();
        check("ck_err_hold", ld_err, 1);
        verify_table("ck_fail_tab");
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ck_err_clear", ld_err, 0);
        check("ck_restart_busy", ld_busy, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
